// File: rtl/grafica_velocidad_multi.sv
// ---------------------------------------------------------------------------
// grafica_velocidad_multi
//   Draws CHANNELS vertical speed bars with a peak-hold marker on an RGB332
//   raster. Speed values are staged in pending registers and move to the
//   display registers only at frame start, so a bar never tears mid-frame.
//   Each peak marker holds for HOLD frames, then decays 1 pixel per frame
//   and never drops below its bar.
//
// Ports
//   clock    : the single clock; everything runs on its rising edge
//   reset_n  : synchronous active-low reset
//   entera   : packed speeds, channel i at [i*VAL_W +: VAL_W]
//   valid    : loads entera into the pending registers
//   hcount   : current pixel column
//   vcount   : current pixel row
//   dout     : registered RGB332 pixel, 2 clocks after hcount/vcount
// ---------------------------------------------------------------------------
module grafica_velocidad_multi #(
  parameter int          CHANNELS = 4,
  parameter int          VAL_W    = 16,
  parameter int          SHIFT    = 0,
  parameter int          MAX_H    = 255,
  parameter int          X0       = 64,
  parameter int          BAR_W    = 96,
  parameter int          GAP      = 32,
  parameter int          Y_BASE   = 400,
  parameter int          HOLD     = 60,
  parameter logic [7:0]  BAR_C    = 8'h1C,
  parameter logic [7:0]  PEAK_C   = 8'hE0,
  parameter logic [7:0]  AXIS_C   = 8'hFF,
  parameter logic [7:0]  BG_C     = 8'h00
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS*VAL_W-1:0] entera,
  input  logic                      valid,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  output logic [7:0]                dout
);

  localparam int HW     = (MAX_H < 2) ? 1 : $clog2(MAX_H + 1);
  localparam int HOLD_W = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
  // Wide enough to hold both the shifted value and MAX_H, so the clamp
  // compare cannot overflow whatever VAL_W is.
  localparam int CMP_W  = (VAL_W > HW) ? VAL_W : HW;
  localparam int AX_LO  = X0;
  localparam int AX_HI  = X0 + CHANNELS * (BAR_W + GAP) - GAP;

  logic frame_start;
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);

  // Stage 1: registered pixel coordinates.
  logic [9:0] hc_q, vc_q;
  // Stage 2: registered colour.
  logic [7:0] pix_q, pix_d;

  logic [CHANNELS-1:0] peak_hit;
  logic [CHANNELS-1:0] bar_hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam int LO = X0 + g * (BAR_W + GAP);
    localparam int HI = LO + BAR_W;

    logic [VAL_W-1:0]  pend_q, pend_d;
    logic [HW-1:0]     h_q, h_d;
    logic [HW-1:0]     peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [CMP_W-1:0]  shifted;
    logic [HW-1:0]     h_new;
    logic              in_span;

    assign shifted = CMP_W'(pend_q >> SHIFT);
    assign h_new   = (shifted > CMP_W'(MAX_H)) ? HW'(MAX_H) : HW'(shifted);

    // NOTE: every always_comb output gets its hold value first, so a path
    // that assigns nothing cannot infer a latch.
    always_comb begin
      pend_d = pend_q;
      h_d    = h_q;
      peak_d = peak_q;
      hold_d = hold_q;
      if (valid) pend_d = entera[g*VAL_W +: VAL_W];
      // The transfer reads pend_q, so a valid in the frame-start cycle
      // lands one frame later.
      if (frame_start) begin
        h_d = h_new;
        if (h_new >= peak_q) begin
          peak_d = h_new;
          hold_d = HOLD_W'(HOLD);
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          // peak_q > h_new >= 0 here, so peak_q - 1 cannot underflow.
          peak_d = ((peak_q - 1'b1) > h_new) ? (peak_q - 1'b1) : h_new;
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        pend_q <= '0;
        h_q    <= '0;
        peak_q <= '0;
        hold_q <= '0;
      end else begin
        pend_q <= pend_d;
        h_q    <= h_d;
        peak_q <= peak_d;
        hold_q <= hold_d;
      end
    end

    // One comparator pair per channel on the stage-1 column.
    assign in_span     = (int'(hc_q) >= LO) && (int'(hc_q) < HI);
    assign peak_hit[g] = in_span && (peak_q != '0) &&
                         (int'(vc_q) == Y_BASE - int'(peak_q));
    // With h_q == 0 this interval is empty, so a zero bar draws nothing.
    assign bar_hit[g]  = in_span && (int'(vc_q) > Y_BASE - int'(h_q)) &&
                         (int'(vc_q) <= Y_BASE);
  end

  always_comb begin
    pix_d = BG_C;
    if (hc_q >= 10'd640 || vc_q >= 10'd480) begin
      pix_d = 8'h00;
    end else if (|peak_hit) begin
      pix_d = PEAK_C;
    end else if (|bar_hit) begin
      pix_d = BAR_C;
    end else if ((int'(vc_q) == Y_BASE + 1) && (int'(hc_q) >= AX_LO) &&
                 (int'(hc_q) < AX_HI)) begin
      pix_d = AXIS_C;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hc_q  <= '0;
      vc_q  <= '0;
      pix_q <= '0;
    end else begin
      hc_q  <= hcount;
      vc_q  <= vcount;
      pix_q <= pix_d;
    end
  end

  assign dout = pix_q;

endmodule

// File: tb/tb_grafica_velocidad_multi.sv
// ---------------------------------------------------------------------------
// tb_grafica_velocidad_multi
//   Directed bench for grafica_velocidad_multi with default parameters.
//   Frames are compressed: a frame is one (0,0) cycle followed by a few probe
//   pixels. A behavioural model predicts every dout; probe pixels also carry
//   hand-computed literal colours.
// ---------------------------------------------------------------------------
module tb_grafica_velocidad_multi;

  localparam int CH     = 4;
  localparam int VW     = 16;
  localparam int SHIFT  = 0;
  localparam int MAX_H  = 255;
  localparam int X0     = 64;
  localparam int BAR_W  = 96;
  localparam int GAP    = 32;
  localparam int Y_BASE = 400;
  localparam int HOLD   = 60;
  localparam logic [7:0] BAR_C  = 8'h1C;
  localparam logic [7:0] PEAK_C = 8'hE0;
  localparam logic [7:0] AXIS_C = 8'hFF;
  localparam logic [7:0] BG_C   = 8'h00;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [CH*VW-1:0]  entera;
  logic              valid;
  logic [9:0]        hcount, vcount;
  logic [7:0]        dout;

  always #5 clock = ~clock;

  grafica_velocidad_multi dut (
    .clock  (clock),
    .reset_n(reset_n),
    .entera (entera),
    .valid  (valid),
    .hcount (hcount),
    .vcount (vcount),
    .dout   (dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dout=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pend[CH];
  int m_h[CH];
  int m_peak[CH];
  int m_hold[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = 0; m_h[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit fs, input bit vld, input logic [CH*VW-1:0] ent);
    if (fs) begin
      for (int c = 0; c < CH; c++) begin
        int hh;
        hh = m_pend[c] >> SHIFT;
        if (hh > MAX_H) hh = MAX_H;
        m_h[c] = hh;
        if (hh >= m_peak[c]) begin
          m_peak[c] = hh;
          m_hold[c] = HOLD;
        end else if (m_hold[c] > 0) begin
          m_hold[c] = m_hold[c] - 1;
        end else begin
          m_peak[c] = (m_peak[c] - 1 > hh) ? m_peak[c] - 1 : hh;
        end
      end
    end
    if (vld)
      for (int c = 0; c < CH; c++) m_pend[c] = int'(ent[c*VW +: VW]);
  endfunction

  function automatic logic [7:0] model_pix(input int h, input int v);
    if (h >= 640 || v >= 480) return 8'h00;
    for (int c = 0; c < CH; c++) begin
      int lo;
      lo = X0 + c * (BAR_W + GAP);
      if (h >= lo && h < lo + BAR_W && m_peak[c] > 0 && v == Y_BASE - m_peak[c])
        return PEAK_C;
    end
    for (int c = 0; c < CH; c++) begin
      int lo;
      lo = X0 + c * (BAR_W + GAP);
      if (h >= lo && h < lo + BAR_W && v > Y_BASE - m_h[c] && v <= Y_BASE)
        return BAR_C;
    end
    if (v == Y_BASE + 1 && h >= X0 && h < X0 + CH * (BAR_W + GAP) - GAP)
      return AXIS_C;
    return BG_C;
  endfunction

  // ---------------- compare process ----------------
  logic        lit_en;
  logic [7:0]  lit_val;
  string       lit_name;

  logic [7:0]  exp_prev;
  logic [7:0]  exp_cur;
  bit          lit_prev_en = 1'b0;
  logic [7:0]  lit_prev_val;
  string       lit_prev_name;
  bit          started = 1'b0;
  bit          rst_now;
  bit          le_now;
  logic [7:0]  lv_now;
  string       ln_now;

  always @(posedge clock) begin
    rst_now = !reset_n;
    le_now  = lit_en;
    lv_now  = lit_val;
    ln_now  = lit_name;
    if (rst_now) model_reset();
    else model_step(hcount == 10'd0 && vcount == 10'd0, valid, entera);
    exp_cur = rst_now ? 8'h00 : model_pix(int'(hcount), int'(vcount));
    #1;
    if (rst_now) begin
      check("reset_dout", dout, 8'h00);
    end else begin
      if (started) check("model", dout, exp_prev);
      if (lit_prev_en) check(lit_prev_name, dout, lit_prev_val);
    end
    started       = 1'b1;
    exp_prev      = exp_cur;
    lit_prev_en   = le_now && !rst_now;
    lit_prev_val  = lv_now;
    lit_prev_name = ln_now;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int h, input int v, input bit vld = 1'b0);
    @(negedge clock);
    hcount  = 10'(h);
    vcount  = 10'(v);
    valid   = vld;
    lit_en  = 1'b0;
  endtask

  task automatic probe(input string nm, input int h, input int v, input logic [7:0] e);
    @(negedge clock);
    hcount   = 10'(h);
    vcount   = 10'(v);
    valid    = 1'b0;
    lit_en   = 1'b1;
    lit_val  = e;
    lit_name = nm;
  endtask

  task automatic set_vals(input int c0, input int c1, input int c2, input int c3);
    entera[0*VW +: VW] = VW'(c0);
    entera[1*VW +: VW] = VW'(c1);
    entera[2*VW +: VW] = VW'(c2);
    entera[3*VW +: VW] = VW'(c3);
  endtask

  initial begin
    reset_n  = 1'b0;
    valid    = 1'b0;
    entera   = '0;
    hcount   = 10'd0;
    vcount   = 10'd0;
    lit_en   = 1'b0;
    lit_val  = 8'h00;
    lit_name = "";

    repeat (3) tick(100, 390);
    reset_n = 1'b1;

    // Empty display after reset.
    probe("empty_bar", 100, 390, BG_C);
    probe("empty_axis", 100, 401, AXIS_C);

    // Channel 0 = 20: bar rows 381..400, peak at 380.
    set_vals(20, 0, 0, 0);
    tick(650, 0, 1'b1);
    tick(0, 0);
    probe("ch0_bar390", 100, 390, BAR_C);
    probe("ch0_peak380", 100, 380, PEAK_C);
    probe("ch0_bg379", 100, 379, BG_C);
    probe("ch0_bar381", 100, 381, BAR_C);
    probe("ch0_base400", 100, 400, BAR_C);

    // Channel 1 = 1000 saturates to 255: peak at 145 wins over the bar.
    set_vals(20, 1000, 0, 0);
    tick(650, 0, 1'b1);
    tick(0, 0);
    probe("ch1_peak145", 200, 145, PEAK_C);
    probe("ch1_bar146", 200, 146, BAR_C);
    probe("ch1_bg144", 200, 144, BG_C);

    // valid coincident with frame start: old bar this frame, new bar next.
    set_vals(50, 1000, 0, 0);
    tick(0, 0, 1'b1);
    probe("coinc_old370", 100, 370, BG_C);
    probe("coinc_old390", 100, 390, BAR_C);
    tick(0, 0);
    probe("coinc_new370", 100, 370, BAR_C);
    probe("coinc_newpk350", 100, 350, PEAK_C);

    // Blanking, gaps and axis extent.
    probe("blank_h650", 650, 390, 8'h00);
    probe("blank_v480", 100, 480, 8'h00);
    probe("gap_h170", 170, 390, BG_C);
    probe("axis_left", 64, 401, AXIS_C);
    probe("axis_right", 543, 401, AXIS_C);
    probe("axis_pre", 63, 401, BG_C);
    probe("axis_post", 544, 401, BG_C);
    probe("axis_gap", 170, 401, AXIS_C);

    // Peak decay on channel 2 (span 320..415).
    set_vals(50, 1000, 100, 0);
    tick(650, 0, 1'b1);
    tick(0, 0);
    probe("decay_pk300", 350, 300, PEAK_C);
    set_vals(50, 1000, 0, 0);
    tick(650, 0, 1'b1);
    for (int f = 1; f <= 160; f++) begin
      tick(0, 0);
      if (f <= 60) begin
        probe("decay_hold", 350, 300, PEAK_C);
      end else if (f < 160) begin
        probe("decay_row", 350, 300 + f - 60, PEAK_C);
        probe("decay_above", 350, 299 + f - 60, BG_C);
      end else begin
        probe("decay_gone400", 350, 400, BG_C);
        probe("decay_axis", 350, 401, AXIS_C);
      end
    end

    // Reset mid-frame, coinciding with valid and frame start.
    probe("pre_rst_bar", 100, 370, BAR_C);
    @(negedge clock);
    reset_n = 1'b0;
    set_vals(77, 77, 77, 77);
    hcount  = 10'd0;
    vcount  = 10'd0;
    valid   = 1'b1;
    lit_en  = 1'b0;
    tick(100, 390);
    reset_n = 1'b1;
    probe("post_rst_bar0", 100, 390, BG_C);
    probe("post_rst_bar1", 200, 146, BG_C);
    probe("post_rst_axis", 100, 401, AXIS_C);
    tick(0, 0);
    probe("post_rst_frame", 100, 390, BG_C);
    probe("post_rst_frame1", 200, 300, BG_C);

    // Bars come back after a valid and a frame start.
    set_vals(20, 0, 0, 0);
    tick(650, 0, 1'b1);
    tick(0, 0);
    probe("recover_bar", 100, 390, BAR_C);

    repeat (3) tick(650, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
